// File: rtl/ariane_pkg.sv
// Core-level types used by the commit stage: functional units, ops, scoreboard entry, commit FSM states.
package ariane_pkg;
   localparam int unsigned REG_ADDR_SIZE = 6;

   typedef enum logic [3:0] {
      NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU
   } fu_t;

   typedef enum logic [3:0] {
      ADD, SUB, LD, SD, FADD, FMUL, FLD, CSR_RW
   } fu_op;

   typedef struct packed {
      logic [riscv::XLEN-1:0] cause;
      logic                   valid;
   } exception_t;

   typedef struct packed {
      fu_t                      fu;
      fu_op                     op;
      logic [REG_ADDR_SIZE-1:0] rd;
      logic [riscv::XLEN-1:0]   result;
      exception_t               ex;
   } scoreboard_entry_t;

   typedef enum logic [1:0] {
      IDLE, WAIT_LSU, WAIT_CSR, FLUSH
   } commit_state_e;

   // Ops whose destination lives in the floating-point register file.
   function automatic logic is_rd_fpr(input fu_op op);
      case (op)
         FADD, FMUL, FLD: return 1'b1;
         default:         return 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/riscv_pkg.sv
// RISC-V architectural constants shared by the commit path: data width and trap cause codes.
package riscv;
   localparam int unsigned XLEN = 64;

   localparam logic [XLEN-1:0] ILLEGAL_INSTR   = 64'd2;
   localparam logic [XLEN-1:0] ST_ACCESS_FAULT = 64'd7;
endpackage

// File: rtl/commit_watchdog.sv
// Saturating wait-cycle counter for the commit sequencer; expired is high once LIMIT cycles have elapsed.
module commit_watchdog #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int unsigned W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

   logic [W-1:0] cnt_q, cnt_d;

   // Clear wins over count; the counter holds at LIMIT instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LIMIT_W)) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LIMIT_W);
endmodule

// File: rtl/commit_sequencer.sv
// Retires the oldest scoreboard entry: register writes, store/CSR handshakes, traps and flush.
// Optional: define COMMIT_SEQUENCER_INSTRET_EN to add the 64-bit instret_o retired-instruction counter.
module commit_sequencer
   import ariane_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  scoreboard_entry_t        commit_instr_i,
   input  logic                     commit_instr_valid_i,
   output logic                     commit_ack_o,
   input  logic                     halt_i,
   output logic [REG_ADDR_SIZE-1:0] waddr_o,
   output logic [riscv::XLEN-1:0]   wdata_o,
   output logic                     we_gpr_o,
   output logic                     we_fpr_o,
   output logic                     commit_lsu_o,
   input  logic                     commit_lsu_ready_i,
   output logic                     csr_op_o,
   input  logic                     csr_done_i,
   output logic                     exception_valid_o,
   output logic [riscv::XLEN-1:0]   exception_cause_o,
`ifdef COMMIT_SEQUENCER_INSTRET_EN
   output logic [63:0]              instret_o,
`endif
   output logic                     flush_o
);
   commit_state_e state_q, state_d;
   logic          start_s;
   logic          waiting_s;
   logic          expired_s;
   logic          wr_s;

   assign start_s   = commit_instr_valid_i && !halt_i;
   assign waiting_s = (state_q == WAIT_LSU) || (state_q == WAIT_CSR);

   // Counter is held clear outside the wait states, so every wait starts from zero.
   commit_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr     (!waiting_s),
      .en      (waiting_s),
      .expired (expired_s)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a same-cycle ready/done never enters the wait state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!start_s) begin
               state_d = IDLE;
            end else if (commit_instr_i.ex.valid) begin
               state_d = FLUSH;
            end else if (commit_instr_i.fu == STORE) begin
               state_d = commit_lsu_ready_i ? IDLE : WAIT_LSU;
            end else if (commit_instr_i.fu == CSR) begin
               state_d = csr_done_i ? FLUSH : WAIT_CSR;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_LSU: begin
            if (commit_lsu_ready_i) begin
               state_d = IDLE;
            end else if (expired_s) begin
               state_d = FLUSH;
            end else begin
               state_d = WAIT_LSU;
            end
         end
         WAIT_CSR: begin
            if (csr_done_i || expired_s) begin
               state_d = FLUSH;
            end else begin
               state_d = WAIT_CSR;
            end
         end
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic; reset also gates the combinational paths so outputs drop immediately.
   always_comb begin
      commit_ack_o      = 1'b0;
      we_gpr_o          = 1'b0;
      we_fpr_o          = 1'b0;
      waddr_o           = '0;
      wdata_o           = '0;
      commit_lsu_o      = 1'b0;
      csr_op_o          = 1'b0;
      exception_valid_o = 1'b0;
      exception_cause_o = '0;
      flush_o           = 1'b0;
      wr_s              = 1'b0;
      if (rst_ni) begin
         case (state_q)
            IDLE: begin
               if (!start_s) begin
                  wr_s = 1'b0;
               end else if (commit_instr_i.ex.valid) begin
                  exception_valid_o = 1'b1;
                  exception_cause_o = commit_instr_i.ex.cause;
                  commit_ack_o      = 1'b1;
               end else if (commit_instr_i.fu == STORE) begin
                  commit_lsu_o = 1'b1;
                  commit_ack_o = commit_lsu_ready_i;
               end else if (commit_instr_i.fu == CSR) begin
                  csr_op_o     = 1'b1;
                  commit_ack_o = csr_done_i;
                  wr_s         = csr_done_i;
               end else begin
                  commit_ack_o = 1'b1;
                  wr_s         = 1'b1;
               end
            end
            WAIT_LSU: begin
               commit_lsu_o = 1'b1;
               if (commit_lsu_ready_i) begin
                  commit_ack_o = 1'b1;
               end else if (expired_s) begin
                  exception_valid_o = 1'b1;
                  exception_cause_o = riscv::ST_ACCESS_FAULT;
                  commit_ack_o      = 1'b1;
               end else begin
                  commit_ack_o = 1'b0;
               end
            end
            WAIT_CSR: begin
               csr_op_o = 1'b1;
               if (csr_done_i) begin
                  commit_ack_o = 1'b1;
                  wr_s         = 1'b1;
               end else if (expired_s) begin
                  exception_valid_o = 1'b1;
                  exception_cause_o = riscv::ILLEGAL_INSTR;
                  commit_ack_o      = 1'b1;
               end else begin
                  commit_ack_o = 1'b0;
               end
            end
            FLUSH:   flush_o = 1'b1;
            default: flush_o = 1'b0;
         endcase
      end else begin
         wr_s = 1'b0;
      end

      // x0 is hardwired, but f0 is a real register.
      if (wr_s && is_rd_fpr(commit_instr_i.op)) begin
         we_fpr_o = 1'b1;
         waddr_o  = commit_instr_i.rd;
         wdata_o  = commit_instr_i.result;
      end else if (wr_s && (commit_instr_i.rd != '0)) begin
         we_gpr_o = 1'b1;
         waddr_o  = commit_instr_i.rd;
         wdata_o  = commit_instr_i.result;
      end else begin
         we_gpr_o = 1'b0;
      end
   end

`ifdef COMMIT_SEQUENCER_INSTRET_EN
   logic [63:0] instret_q, instret_d;

   // Count retirements that are not trap reports.
   always_comb begin
      if (commit_ack_o && !exception_valid_o) begin
         instret_d = instret_q + 64'd1;
      end else begin
         instret_d = instret_q;
      end
   end

   // Retired-instruction counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         instret_q <= 64'd0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign instret_o = instret_q;
`endif
endmodule

// File: tb/tb_commit_sequencer.sv
// Directed bench for commit_sequencer: single-cycle vector table plus multi-cycle wait/timeout/reset sequences.
module tb_commit_sequencer;
   import ariane_pkg::*;

   typedef struct packed {
      logic        ack;
      logic        we_gpr;
      logic        we_fpr;
      logic [5:0]  waddr;
      logic [63:0] wdata;
      logic        lsu;
      logic        csr;
      logic        exv;
      logic [63:0] cause;
      logic        flush;
   } out_t;

   typedef struct {
      fu_t         fu;
      fu_op        op;
      logic [5:0]  rd;
      logic [63:0] res;
      logic        exv;
      logic [63:0] cause;
      logic        valid;
      logic        halt;
      logic        ready;
      logic        done;
      out_t        exp;
   } vec_t;

   logic              clk;
   logic              rst_ni;
   scoreboard_entry_t entry;
   logic              valid, halt, ready, done;
   logic              ack, we_gpr, we_fpr, lsu, csr, exv, flush;
   logic [5:0]        waddr;
   logic [63:0]       wdata, cause;
   out_t              got;
   int                n_checks;
   int                n_errors;
   vec_t              vecs[$];
`ifdef COMMIT_SEQUENCER_INSTRET_EN
   logic [63:0]       instret;
`endif

   commit_sequencer #(.TIMEOUT_CYCLES(4)) dut (
      .clk_i                (clk),
      .rst_ni               (rst_ni),
      .commit_instr_i       (entry),
      .commit_instr_valid_i (valid),
      .commit_ack_o         (ack),
      .halt_i               (halt),
      .waddr_o              (waddr),
      .wdata_o              (wdata),
      .we_gpr_o             (we_gpr),
      .we_fpr_o             (we_fpr),
      .commit_lsu_o         (lsu),
      .commit_lsu_ready_i   (ready),
      .csr_op_o             (csr),
      .csr_done_i           (done),
      .exception_valid_o    (exv),
      .exception_cause_o    (cause),
`ifdef COMMIT_SEQUENCER_INSTRET_EN
      .instret_o            (instret),
`endif
      .flush_o              (flush)
   );

   assign got = {ack, we_gpr, we_fpr, waddr, wdata, lsu, csr, exv, cause, flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t mk_out(input logic a, input logic g, input logic f, input logic [5:0] wa,
                                   input logic [63:0] wd, input logic l, input logic c, input logic e,
                                   input logic [63:0] ca, input logic fl);
      return '{ack: a, we_gpr: g, we_fpr: f, waddr: wa, wdata: wd, lsu: l, csr: c, exv: e, cause: ca, flush: fl};
   endfunction

   task automatic drive(input fu_t fu, input fu_op op, input logic [5:0] rd, input logic [63:0] res,
                        input logic ev, input logic [63:0] ec, input logic v, input logic h,
                        input logic r, input logic d);
      entry.fu       = fu;
      entry.op       = op;
      entry.rd       = rd;
      entry.result   = res;
      entry.ex.valid = ev;
      entry.ex.cause = ec;
      valid = v;
      halt  = h;
      ready = r;
      done  = d;
   endtask

   task automatic compare(input string name, input out_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Sample at the falling edge, then step past the next rising edge.
   task automatic check_cycle(input string name, input out_t exp);
      @(negedge clk);
      compare(name, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input fu_t fu, input fu_op op, input logic [5:0] rd, input logic [63:0] res,
                          input logic ev, input logic [63:0] ec, input logic v, input logic h,
                          input logic r, input logic d, input out_t exp);
      vec_t x;
      x.fu = fu; x.op = op; x.rd = rd; x.res = res; x.exv = ev; x.cause = ec;
      x.valid = v; x.halt = h; x.ready = r; x.done = d; x.exp = exp;
      vecs.push_back(x);
   endtask

   initial begin
      out_t z;
      z = '0;
      n_checks = 0;
      n_errors = 0;

      // Rows are consecutive cycles; an exception or CSR completion puts the next row in FLUSH.
      add_vec(ALU, ADD, 6'd5, 64'h1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, z);
      add_vec(ALU, ADD, 6'd5, 64'hDEAD, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0,
              mk_out(1'b1, 1'b1, 1'b0, 6'd5, 64'hDEAD, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0));
      add_vec(ALU, SUB, 6'd0, 64'h1234, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0,
              mk_out(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0));
      add_vec(FPU, FADD, 6'd3, 64'h3FF0_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0,
              mk_out(1'b1, 1'b0, 1'b1, 6'd3, 64'h3FF0_0000_0000_0000, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0));
      add_vec(FPU, FMUL, 6'd0, 64'h55, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0,
              mk_out(1'b1, 1'b0, 1'b1, 6'd0, 64'h55, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0));
      add_vec(ALU, ADD, 6'd7, 64'h99, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, z);
      add_vec(STORE, SD, 6'd0, 64'h0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0,
              mk_out(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0));
      add_vec(ALU, ADD, 6'd9, 64'h42, 1'b1, 64'd5, 1'b1, 1'b0, 1'b0, 1'b0,
              mk_out(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd5, 1'b0));
      add_vec(ALU, ADD, 6'd5, 64'h7, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0,
              mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1));
      add_vec(CSR, CSR_RW, 6'd4, 64'h77, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1,
              mk_out(1'b1, 1'b1, 1'b0, 6'd4, 64'h77, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0));
      add_vec(ALU, ADD, 6'd1, 64'h0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0,
              mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1));
      add_vec(CSR, CSR_RW, 6'd0, 64'h88, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1,
              mk_out(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0));
      add_vec(ALU, ADD, 6'd1, 64'h0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0,
              mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1));
      add_vec(STORE, SD, 6'd0, 64'h0, 1'b1, 64'hD, 1'b1, 1'b0, 1'b1, 1'b0,
              mk_out(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'hD, 1'b0));
      add_vec(ALU, ADD, 6'd1, 64'h0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0,
              mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1));
      add_vec(ALU, ADD, 6'd2, 64'h3, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, z);
      add_vec(ALU, ADD, 6'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0,
              mk_out(1'b1, 1'b1, 1'b0, 6'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0));

      // Reset holds every output low even with a committable entry presented.
      rst_ni = 1'b0;
      drive(ALU, ADD, 6'd5, 64'hDEAD, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      #3;
      compare("reset_outputs", z);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].fu, vecs[i].op, vecs[i].rd, vecs[i].res, vecs[i].exv, vecs[i].cause,
               vecs[i].valid, vecs[i].halt, vecs[i].ready, vecs[i].done);
         check_cycle($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Store acked on cycle 3; halt raised mid-wait must not stall it.
      drive(STORE, SD, 6'd0, 64'h0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_cycle("store_c0", mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0));
      halt = 1'b1;
      check_cycle("store_c1", mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0));
      check_cycle("store_c2", mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0));
      ready = 1'b1;
      check_cycle("store_c3", mk_out(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0));
      drive(ALU, ADD, 6'd0, 64'h0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_cycle("store_c4", z);

      // CSR with no done: four silent wait cycles, then cause 2, then flush.
      drive(CSR, CSR_RW, 6'd4, 64'h11, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         check_cycle($sformatf("csr_to_c%0d", c),
                     mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0));
      end
      check_cycle("csr_to_trap", mk_out(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b1, 1'b1, 64'd2, 1'b0));
      valid = 1'b0;
      check_cycle("csr_to_flush", mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1));
      check_cycle("csr_to_idle", z);

      // Store with no ready: cause 7 after the same wait.
      drive(STORE, SD, 6'd0, 64'h0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         check_cycle($sformatf("st_to_c%0d", c),
                     mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0));
      end
      check_cycle("st_to_trap", mk_out(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd7, 1'b0));
      valid = 1'b0;
      check_cycle("st_to_flush", mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1));

      // Reset in the middle of a store wait: outputs drop at once, FSM restarts in IDLE.
      drive(STORE, SD, 6'd0, 64'h0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_cycle("rst_c0", mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0));
      check_cycle("rst_c1", mk_out(1'b0, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0));
      #1;
      rst_ni = 1'b0;
      #1;
      compare("rst_mid_wait", z);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      drive(ALU, ADD, 6'd6, 64'hBEEF, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_cycle("rst_after", mk_out(1'b1, 1'b1, 1'b0, 6'd6, 64'hBEEF, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/commit_sequencer.md
COMMIT_SEQUENCER -- requirements
Module: commit_sequencer

Interface
REQ-001: The block SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum cycles spent waiting in WAIT_LSU or WAIT_CSR.
REQ-002: The block SHALL have clk_i, input, 1 bit: the single clock.
REQ-003: The block SHALL have rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004: The block SHALL have commit_instr_i, input, ariane_pkg::scoreboard_entry_t: the oldest scoreboard entry.
REQ-005: The block SHALL have commit_instr_valid_i, input, 1 bit: commit_instr_i is valid.
REQ-006: The block SHALL have commit_ack_o, output, 1 bit: the entry is retired; the scoreboard advances its commit pointer.
REQ-007: The block SHALL have halt_i, input, 1 bit: blocks the start of any new commit.
REQ-008: The block SHALL have waddr_o, output, REG_ADDR_SIZE bits: register-file write address.
REQ-009: The block SHALL have wdata_o, output, XLEN bits: register-file write data.
REQ-010: The block SHALL have we_gpr_o and we_fpr_o, outputs, 1 bit each: GPR and FPR write enables.
REQ-011: The block SHALL have commit_lsu_o, output, 1 bit, and commit_lsu_ready_i, input, 1 bit: the store-commit handshake.
REQ-012: The block SHALL have csr_op_o, output, 1 bit, and csr_done_i, input, 1 bit: the CSR-commit handshake.
REQ-013: The block SHALL have exception_valid_o, output, 1 bit, and exception_cause_o, output, XLEN bits: the trap report.
REQ-014: The block SHALL have flush_o, output, 1 bit: a one-cycle pipeline flush pulse.

Function
REQ-015: The FSM SHALL have the states IDLE, WAIT_LSU, WAIT_CSR and FLUSH.
REQ-016: In IDLE with valid=1, halt_i=0, ex.valid=0 and fu not STORE/CSR, the block SHALL assert commit_ack_o and the selected write enable combinationally in the same cycle, then remain in IDLE.
REQ-017: The block SHALL suppress we_gpr_o when rd=0; commit_ack_o is still asserted.
REQ-018: The block SHALL select we_fpr_o over we_gpr_o when rd is an FPR destination (ariane_pkg::is_rd_fpr).
REQ-019: In IDLE with valid=1 and ex.valid=1, the block SHALL assert exception_valid_o, drive exception_cause_o=ex.cause and assert commit_ack_o in the same cycle, with no register write, then go to FLUSH.
REQ-020: For fu=STORE in IDLE, the block SHALL assert commit_lsu_o and go to WAIT_LSU; commit_lsu_o SHALL stay high until commit_lsu_ready_i=1, in that cycle commit_ack_o is asserted and the FSM returns to IDLE.
REQ-021: For fu=CSR in IDLE, the block SHALL assert csr_op_o and go to WAIT_CSR; on csr_done_i=1 it SHALL ack, write rd (GPR rule REQ-017 applies) and go to FLUSH.
REQ-022: A ready or done that arrives in the same cycle as the request SHALL complete in that cycle without entering the wait state.
REQ-023: In FLUSH, the block SHALL assert flush_o for exactly one cycle with no ack, then go to IDLE.
REQ-024: If the timeout counter reaches TIMEOUT_CYCLES in WAIT_LSU, the block SHALL report cause 7 (store access fault), ack, and go to FLUSH; in WAIT_CSR the cause SHALL be 2 (illegal instruction).
REQ-025: The timeout counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide, clear on entering any wait state and saturate, never wrap.
REQ-026: halt_i SHALL gate only IDLE; a commit already in WAIT_LSU or WAIT_CSR SHALL run to completion.
REQ-027: commit_instr_valid_i=0 in IDLE SHALL produce no outputs; the block SHALL assume the entry is held stable while waiting.
REQ-028: At most one commit_ack_o SHALL occur per cycle.

Reset
REQ-029: rst_ni=0 SHALL immediately force state IDLE, the counter to 0, and all outputs to 0, including mid-wait; the aborted entry is not acked.

Configuration
REQ-030: With COMMIT_SEQUENCER_INSTRET_EN defined, the block SHALL add output instret_o, 64 bits, a counter that is reset to 0 and increments once per non-exception commit_ack_o.
REQ-031: Without COMMIT_SEQUENCER_INSTRET_EN, neither the port nor the counter SHALL exist.

Structure
REQ-032: The commit_state_e enum SHALL live in ariane_pkg; cause codes SHALL come from the riscv package constants.
REQ-033: The timeout counter SHALL be a sub-module named commit_watchdog (inputs clr and en; output expired).

Verification
REQ-034: ALU entry, rd=5, result 0xDEAD, valid=1 -> same-cycle ack, we_gpr_o=1, waddr_o=5, wdata_o=0xDEAD.
REQ-035: ALU entry with rd=0 -> ack=1, we_gpr_o=0.
REQ-036: Store entry, ready raised on cycle 3 -> commit_lsu_o high for cycles 0-3, single ack on cycle 3.
REQ-037: ex.valid=1, cause=5 -> exception_valid_o=1, cause=5, ack the same cycle, flush_o=1 the next cycle only.
REQ-038: CSR entry, csr_done_i never asserted, TIMEOUT_CYCLES=4 -> exception cause 2 after 4 wait cycles, then flush_o.
REQ-039: rst_ni dropped in WAIT_LSU -> outputs 0 immediately, FSM in IDLE after release, no ack.
